systolic_seq: RTL

SYSTOLIC_SEQ -- requirements
Module: systolic_seq

---
 rtl/systolic_pkg.sv | 15 +
 rtl/systolic_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the 2x2 systolic matrix-multiply sequencer.
package systolic_pkg;

  localparam int TILE_SIZE      = 2;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/systolic_seq.sv
// Sequencer that clears a 2x2 systolic array, feeds skewed operand edges,
// drains it with zero beats and pulses DONE; all outputs come from flops.
module systolic_seq
  import systolic_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic [DATA_W-1:0] A00,
  input  logic [DATA_W-1:0] A01,
  input  logic [DATA_W-1:0] A10,
  input  logic [DATA_W-1:0] A11,
  input  logic [DATA_W-1:0] B00,
  input  logic [DATA_W-1:0] B01,
  input  logic [DATA_W-1:0] B10,
  input  logic [DATA_W-1:0] B11,
  output logic              BUSY,
  output logic              DONE,
  output logic              ARR_EN,
  output logic              ARR_CLR,
  output logic [DATA_W-1:0] N_RX0,
  output logic [DATA_W-1:0] N_RX1,
  output logic [DATA_W-1:0] N_CX0,
  output logic [DATA_W-1:0] N_CX1
);

  localparam logic [1:0] FEED_LAST  = 2'(2 * TILE_SIZE - 2);
  localparam logic       NO_DRAIN   = (DRAIN_CYCLES == 0);
  localparam logic [2:0] DRAIN_LAST = (DRAIN_CYCLES == 0) ? 3'd0 : 3'(DRAIN_CYCLES - 1);

  state_t            state_r, state_n;
  logic [1:0]        step_r, step_n;
  logic [2:0]        drain_r, drain_n;
  logic              capture_s;
  logic [DATA_W-1:0] a00_r, a01_r, a10_r, a11_r;
  logic [DATA_W-1:0] b00_r, b01_r, b10_r, b11_r;
  logic              busy_r, done_r, en_r, clr_r;
  logic              busy_n, done_n, en_n, clr_n;
  logic [DATA_W-1:0] rx0_r, rx1_r, cx0_r, cx1_r;
  logic [DATA_W-1:0] rx0_n, rx1_n, cx0_n, cx1_n;

  // Next-state logic; START is only looked at in IDLE so it never queues.
  always_comb begin
    state_n   = state_r;
    step_n    = step_r;
    drain_n   = drain_r;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          state_n   = ST_CLEAR;
          capture_s = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_n = ST_FEED;
        step_n  = 2'd0;
      end
      ST_FEED: begin
        if (step_r == FEED_LAST) begin
          if (NO_DRAIN) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_DRAIN;
            drain_n = 3'd0;
          end
        end else begin
          step_n = step_r + 2'd1;
        end
      end
      ST_DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          state_n = ST_DONE;
        end else begin
          drain_n = drain_r + 3'd1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Output values for the upcoming state, so the ports themselves are flops.
  always_comb begin
    busy_n = (state_n != ST_IDLE);
    done_n = (state_n == ST_DONE);
    en_n   = (state_n == ST_FEED) || (state_n == ST_DRAIN);
    clr_n  = (state_n == ST_CLEAR);
    rx0_n  = {DATA_W{1'b0}};
    rx1_n  = {DATA_W{1'b0}};
    cx0_n  = {DATA_W{1'b0}};
    cx1_n  = {DATA_W{1'b0}};
    if (state_n == ST_FEED) begin
      // Row r and column c are delayed by r and c beats respectively.
      case (step_n)
        2'd0: begin
          rx0_n = a00_r;
          cx0_n = b00_r;
        end
        2'd1: begin
          rx0_n = a01_r;
          rx1_n = a10_r;
          cx0_n = b10_r;
          cx1_n = b01_r;
        end
        2'd2: begin
          rx1_n = a11_r;
          cx1_n = b11_r;
        end
        default: begin
          rx0_n = {DATA_W{1'b0}};
        end
      endcase
    end else begin
      rx0_n = {DATA_W{1'b0}};
    end
  end

  // State, counters, captured operands and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_r <= ST_IDLE;
      step_r  <= 2'd0;
      drain_r <= 3'd0;
      a00_r   <= {DATA_W{1'b0}};
      a01_r   <= {DATA_W{1'b0}};
      a10_r   <= {DATA_W{1'b0}};
      a11_r   <= {DATA_W{1'b0}};
      b00_r   <= {DATA_W{1'b0}};
      b01_r   <= {DATA_W{1'b0}};
      b10_r   <= {DATA_W{1'b0}};
      b11_r   <= {DATA_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      en_r    <= 1'b0;
      clr_r   <= 1'b0;
      rx0_r   <= {DATA_W{1'b0}};
      rx1_r   <= {DATA_W{1'b0}};
      cx0_r   <= {DATA_W{1'b0}};
      cx1_r   <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_n;
      step_r  <= step_n;
      drain_r <= drain_n;
      if (capture_s) begin
        a00_r <= A00;
        a01_r <= A01;
        a10_r <= A10;
        a11_r <= A11;
        b00_r <= B00;
        b01_r <= B01;
        b10_r <= B10;
        b11_r <= B11;
      end
      busy_r <= busy_n;
      done_r <= done_n;
      en_r   <= en_n;
      clr_r  <= clr_n;
      rx0_r  <= rx0_n;
      rx1_r  <= rx1_n;
      cx0_r  <= cx0_n;
      cx1_r  <= cx1_n;
    end
  end

  assign BUSY    = busy_r;
  assign DONE    = done_r;
  assign ARR_EN  = en_r;
  assign ARR_CLR = clr_r;
  assign N_RX0   = rx0_r;
  assign N_RX1   = rx1_r;
  assign N_CX0   = cx0_r;
  assign N_CX1   = cx1_r;

endmodule
